// File: rtl/mem_axi_upsizer.sv
// 64-bit core AXI4 master to 128-bit DDR AXI4 slave bridge.
// Remaps addresses, steers write strobes into byte lanes and picks read halves per beat.
module mem_axi_upsizer #(
  parameter logic [3:0] BASE_NIBBLE = 4'h1,
  parameter int S_ID_W   = 4,
  parameter int M_ID_W   = 6,
  parameter int M_ADDR_W = 49
) (
  input  logic                clock,
  input  logic                reset_n,
  // core write address
  input  logic                s_aw_valid,
  output logic                s_aw_ready,
  input  logic [S_ID_W-1:0]   s_aw_id,
  input  logic [31:0]         s_aw_addr,
  input  logic [7:0]          s_aw_len,
  input  logic [2:0]          s_aw_size,
  input  logic [1:0]          s_aw_burst,
  input  logic                s_aw_lock,
  input  logic [3:0]          s_aw_cache,
  input  logic [2:0]          s_aw_prot,
  input  logic [3:0]          s_aw_qos,
  // core write data
  input  logic                s_w_valid,
  output logic                s_w_ready,
  input  logic [63:0]         s_w_data,
  input  logic [7:0]          s_w_strb,
  input  logic                s_w_last,
  // core write response
  output logic                s_b_valid,
  input  logic                s_b_ready,
  output logic [S_ID_W-1:0]   s_b_id,
  output logic [1:0]          s_b_resp,
  // core read address
  input  logic                s_ar_valid,
  output logic                s_ar_ready,
  input  logic [S_ID_W-1:0]   s_ar_id,
  input  logic [31:0]         s_ar_addr,
  input  logic [7:0]          s_ar_len,
  input  logic [2:0]          s_ar_size,
  input  logic [1:0]          s_ar_burst,
  input  logic                s_ar_lock,
  input  logic [3:0]          s_ar_cache,
  input  logic [2:0]          s_ar_prot,
  input  logic [3:0]          s_ar_qos,
  // core read data
  output logic                s_r_valid,
  input  logic                s_r_ready,
  output logic [S_ID_W-1:0]   s_r_id,
  output logic [63:0]         s_r_data,
  output logic [1:0]          s_r_resp,
  output logic                s_r_last,
  // DDR write address
  output logic                m_aw_valid,
  input  logic                m_aw_ready,
  output logic [M_ID_W-1:0]   m_aw_id,
  output logic [M_ADDR_W-1:0] m_aw_addr,
  output logic [7:0]          m_aw_len,
  output logic [2:0]          m_aw_size,
  output logic [1:0]          m_aw_burst,
  output logic                m_aw_lock,
  output logic [3:0]          m_aw_cache,
  output logic [2:0]          m_aw_prot,
  output logic [3:0]          m_aw_qos,
  // DDR write data
  output logic                m_w_valid,
  input  logic                m_w_ready,
  output logic [127:0]        m_w_data,
  output logic [15:0]         m_w_strb,
  output logic                m_w_last,
  // DDR write response
  input  logic                m_b_valid,
  output logic                m_b_ready,
  input  logic [M_ID_W-1:0]   m_b_id,
  input  logic [1:0]          m_b_resp,
  // DDR read address
  output logic                m_ar_valid,
  input  logic                m_ar_ready,
  output logic [M_ID_W-1:0]   m_ar_id,
  output logic [M_ADDR_W-1:0] m_ar_addr,
  output logic [7:0]          m_ar_len,
  output logic [2:0]          m_ar_size,
  output logic [1:0]          m_ar_burst,
  output logic                m_ar_lock,
  output logic [3:0]          m_ar_cache,
  output logic [2:0]          m_ar_prot,
  output logic [3:0]          m_ar_qos,
  // DDR read data
  input  logic                m_r_valid,
  output logic                m_r_ready,
  input  logic [M_ID_W-1:0]   m_r_id,
  input  logic [127:0]        m_r_data,
  input  logic [1:0]          m_r_resp,
  input  logic                m_r_last
);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  w_state_t    w_state;
  r_state_t    r_state;
  logic [11:0] w_addr;
  logic [11:0] r_addr;
  logic        unused_bits;

  // Beat addresses never leave a 4KB page, so 12 bits carry all the arithmetic.
  function automatic logic [11:0] next_beat(input logic [11:0] addr, input logic [7:0] len,
                                            input logic [2:0] size, input logic [1:0] burst);
    logic [1:0]  sz;
    logic [11:0] inc;
    logic [11:0] mask;
    sz   = (size > 3'd3) ? 2'd3 : size[1:0];
    inc  = 12'd1 << sz;
    mask = (({4'd0, len} + 12'd1) << sz) - 12'd1;
    case (burst)
      2'b01:   return addr + inc;
      2'b10:   return (addr & ~mask) | ((addr + inc) & mask);
      default: return addr;
    endcase
  endfunction

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      w_state    <= W_IDLE;
      s_aw_ready <= 1'b0;
      m_aw_valid <= 1'b0;
      m_aw_id    <= '0;
      m_aw_addr  <= '0;
      m_aw_len   <= '0;
      m_aw_size  <= '0;
      m_aw_burst <= '0;
      m_aw_lock  <= 1'b0;
      m_aw_cache <= '0;
      m_aw_prot  <= '0;
      m_aw_qos   <= '0;
      w_addr     <= '0;
    end else begin
      if (m_aw_valid && m_aw_ready)
        m_aw_valid <= 1'b0;
      case (w_state)
        W_IDLE: begin
          if (s_aw_valid && s_aw_ready) begin
            m_aw_valid <= 1'b1;
            m_aw_id    <= {{(M_ID_W-S_ID_W){1'b0}}, s_aw_id};
            m_aw_addr  <= {{(M_ADDR_W-32){1'b0}}, BASE_NIBBLE, s_aw_addr[27:0]};
            m_aw_len   <= s_aw_len;
            m_aw_size  <= s_aw_size;
            m_aw_burst <= s_aw_burst;
            m_aw_lock  <= s_aw_lock;
            m_aw_cache <= s_aw_cache;
            m_aw_prot  <= s_aw_prot;
            m_aw_qos   <= s_aw_qos;
            w_addr     <= s_aw_addr[11:0];
            s_aw_ready <= 1'b0;
            w_state    <= W_DATA;
          end else begin
            s_aw_ready <= !(m_aw_valid && !m_aw_ready);
          end
        end
        W_DATA: begin
          if (s_w_valid && s_w_ready) begin
            w_addr <= next_beat(w_addr, m_aw_len, m_aw_size, m_aw_burst);
            if (s_w_last)
              w_state <= W_RESP;
          end
        end
        W_RESP: begin
          if (m_b_valid && s_b_ready) begin
            w_state    <= W_IDLE;
            s_aw_ready <= !(m_aw_valid && !m_aw_ready);
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= R_IDLE;
      s_ar_ready <= 1'b0;
      m_ar_valid <= 1'b0;
      m_ar_id    <= '0;
      m_ar_addr  <= '0;
      m_ar_len   <= '0;
      m_ar_size  <= '0;
      m_ar_burst <= '0;
      m_ar_lock  <= 1'b0;
      m_ar_cache <= '0;
      m_ar_prot  <= '0;
      m_ar_qos   <= '0;
      r_addr     <= '0;
    end else begin
      if (m_ar_valid && m_ar_ready)
        m_ar_valid <= 1'b0;
      case (r_state)
        R_IDLE: begin
          if (s_ar_valid && s_ar_ready) begin
            m_ar_valid <= 1'b1;
            m_ar_id    <= {{(M_ID_W-S_ID_W){1'b0}}, s_ar_id};
            m_ar_addr  <= {{(M_ADDR_W-32){1'b0}}, BASE_NIBBLE, s_ar_addr[27:0]};
            m_ar_len   <= s_ar_len;
            m_ar_size  <= s_ar_size;
            m_ar_burst <= s_ar_burst;
            m_ar_lock  <= s_ar_lock;
            m_ar_cache <= s_ar_cache;
            m_ar_prot  <= s_ar_prot;
            m_ar_qos   <= s_ar_qos;
            r_addr     <= s_ar_addr[11:0];
            s_ar_ready <= 1'b0;
            r_state    <= R_DATA;
          end else begin
            s_ar_ready <= !(m_ar_valid && !m_ar_ready);
          end
        end
        R_DATA: begin
          if (m_r_valid && s_r_ready) begin
            r_addr <= next_beat(r_addr, m_ar_len, m_ar_size, m_ar_burst);
            if (m_r_last) begin
              r_state    <= R_IDLE;
              s_ar_ready <= !(m_ar_valid && !m_ar_ready);
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // Data channels are gated by state so nothing leaks through outside a burst.
  assign m_w_valid = s_w_valid && (w_state == W_DATA);
  assign s_w_ready = m_w_ready && (w_state == W_DATA);
  assign m_w_data  = {s_w_data, s_w_data};
  assign m_w_strb  = w_addr[3] ? {s_w_strb, 8'h00} : {8'h00, s_w_strb};
  assign m_w_last  = s_w_last;

  assign s_b_valid = m_b_valid && (w_state == W_RESP);
  assign m_b_ready = s_b_ready && (w_state == W_RESP);
  assign s_b_id    = m_b_id[S_ID_W-1:0];
  assign s_b_resp  = m_b_resp;

  assign s_r_valid = m_r_valid && (r_state == R_DATA);
  assign m_r_ready = s_r_ready && (r_state == R_DATA);
  assign s_r_id    = m_r_id[S_ID_W-1:0];
  assign s_r_data  = r_addr[3] ? m_r_data[127:64] : m_r_data[63:0];
  assign s_r_resp  = m_r_resp;
  assign s_r_last  = m_r_last;

  assign unused_bits = ^{s_aw_addr[31:28], s_ar_addr[31:28],
                         m_b_id[M_ID_W-1:S_ID_W], m_r_id[M_ID_W-1:S_ID_W]};

endmodule
